// File: rtl/mem_dma_engine_if.sv
// Purpose     : memory-port bundle between the DMA initiator and the 256 x 8 data memory.
// Latency     : none; read data is a combinational function of mem_addr, writes commit on posedge.
// Backpressure: none; the memory accepts every strobe in the cycle it is presented.
// Ports       : mem_read/mem_write strobes, mem_addr, mem_wdata (initiator -> memory),
//               mem_rdata (memory -> initiator).
interface mem_dma_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Initiator side (the DMA engine).
    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    // Target side (the memory).
    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_dma_engine.sv
// Purpose     : block copy (src -> dst) and block fill (constant -> dst) engine on the data-memory port.
// Latency     : start edge to done pulse is 2N+1 cycles for copy, N+1 for fill, 1 for a zero-length request.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while a transfer runs.
// Ports       : clk, reset (sync, active-low); start/mode/src_addr/dst_addr/length/fill_value request
//               fields sampled with start; mem_bus memory initiator port; busy, done, remaining status.
module mem_dma_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   fill_value,
    mem_dma_engine_if.master    mem_bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     remaining
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   rem_q;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              done_q;

    // Pointers wrap naturally at 2**ADDR_W.
    logic [ADDR_W-1:0] src_inc;
    logic [ADDR_W-1:0] dst_inc;
    assign src_inc = src_q + 1'b1;
    assign dst_inc = dst_q + 1'b1;

    // Every output is a register loaded with the value that belongs to the
    // state being entered, so nothing depends combinationally on inputs.
    // wdata_q doubles as the copy buffer: a byte read in READ is presented
    // unchanged in the following WRITE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        rem_q  <= length;
                        if (length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (!mode) begin
                            state_q <= S_READ;
                            rd_q    <= 1'b1;
                            addr_q  <= src_addr;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_WRITE;
                            wr_q    <= 1'b1;
                            addr_q  <= dst_addr;
                            wdata_q <= fill_value;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    state_q <= S_WRITE;
                    src_q   <= src_inc;
                    wdata_q <= mem_bus.mem_rdata;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b1;
                    addr_q  <= dst_q;
                end

                S_WRITE: begin
                    dst_q <= dst_inc;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == REM_ONE) begin
                        state_q <= S_DONE;
                        wr_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (!mode_q) begin
                        // src_q already points at the next source byte.
                        state_q <= S_READ;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
                        addr_q  <= src_q;
                        wdata_q <= '0;
                    end else begin
                        // Fill keeps the latched byte in wdata_q.
                        addr_q <= dst_inc;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    rem_q   <= '0;
                end
            endcase
        end
    end

    assign mem_bus.mem_read  = rd_q;
    assign mem_bus.mem_write = wr_q;
    assign mem_bus.mem_addr  = addr_q;
    assign mem_bus.mem_wdata = wdata_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign remaining         = rem_q;

endmodule

// File: tb/tb_mem_dma_engine.sv
// Purpose     : self-checking bench for mem_dma_engine against a byte-array reference of the memory.
// Latency     : checks the per-cycle bus activity and the done cycle of every transfer.
// Backpressure: n/a; the bench models a memory that accepts every strobe.
module tb_mem_dma_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [8:0] length;
    logic [7:0] fill_value;
    logic       busy;
    logic       done;
    logic [8:0] remaining;

    always #5 clk = ~clk;

    mem_dma_engine_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_dma_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .mem_bus    (bus),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    // Memory: combinational read, posedge write; a preload port lets the
    // bench seed contents while the engine is idle.
    logic [7:0] mem  [256];
    logic [7:0] refm [256];
    logic       pl_we;
    logic [7:0] pl_addr;
    logic [7:0] pl_dat;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_write)
            mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pl_we)
            mem[pl_addr] <= pl_dat;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic rd, input logic wr, input logic [7:0] addr,
                                         input logic [7:0] wd, input logic bsy, input logic dn,
                                         input logic [8:0] rem);
        return {3'b000, rd, wr, addr, wd, bsy, dn, rem};
    endfunction

    // Address only matters under a strobe, write data only under a write.
    function automatic logic [31:0] obs_vec();
        return pack(bus.mem_read, bus.mem_write,
                    (bus.mem_read | bus.mem_write) ? bus.mem_addr : 8'h00,
                    bus.mem_write ? bus.mem_wdata : 8'h00,
                    busy, done, remaining);
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_dat  = v;
        refm[a] = v;
        @(negedge clk);
        pl_we   = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int k = 0; k < 256; k++)
            check($sformatf("%s mem[%0d]", tag, k), {24'h0, mem[k]}, {24'h0, refm[k]});
    endtask

    // One transfer, checked cycle by cycle. Cycle c is the c-th cycle after
    // the start edge. Copy moves byte i in cycles 2i+1 (read) and 2i+2 (write);
    // fill writes byte i in cycle i+1; done lands in the cycle after the last.
    // inject: stray starts in mid-transfer and in the done cycle.
    // abort_at: cycle after whose sampling reset is asserted (0 = never).
    task automatic do_xfer(input string tag, input bit m, input int s, input int d, input int n,
                           input logic [7:0] fv, input bit inject, input int abort_at);
        int         total;
        int         i;
        logic [7:0] a;
        logic [7:0] rv;
        logic [31:0] e;
        total = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
        rv = 8'h00;
        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        src_addr   = 8'(s);
        dst_addr   = 8'(d);
        length     = 9'(n);
        fill_value = fv;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (c == total) begin
                e = pack(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 9'd0);
            end else if (m) begin
                i = c - 1;
                a = 8'(d + i);
                e = pack(1'b0, 1'b1, a, fv, 1'b1, 1'b0, 9'(n - i));
                refm[a] = fv;
            end else begin
                i = (c - 1) / 2;
                if (c % 2 == 1) begin
                    a  = 8'(s + i);
                    rv = refm[a];
                    e  = pack(1'b1, 1'b0, a, 8'h00, 1'b1, 1'b0, 9'(n - i));
                end else begin
                    a = 8'(d + i);
                    e = pack(1'b0, 1'b1, a, rv, 1'b1, 1'b0, 9'(n - i));
                    refm[a] = rv;
                end
            end
            check($sformatf("%s cyc%0d", tag, c), obs_vec(), e);
            start = 1'b0;
            if (inject && c == 2) begin
                start      = 1'b1;
                mode       = ~m;
                src_addr   = 8'(s + 77);
                dst_addr   = 8'(d + 33);
                length     = 9'd7;
                fill_value = ~fv;
            end
            if (inject && c == total) begin
                start    = 1'b1;
                mode     = 1'b1;
                dst_addr = 8'(d + 1);
                length   = 9'd5;
            end
            if (c == abort_at) begin
                reset = 1'b0;
                @(negedge clk);
                check($sformatf("%s abort_idle", tag), obs_vec(), 32'h0);
                reset = 1'b1;
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s post_idle", tag), obs_vec(), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, required finish before 5 ms");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        src_addr   = 8'h00;
        dst_addr   = 8'h00;
        length     = 9'd0;
        fill_value = 8'h00;
        pl_we      = 1'b0;
        pl_addr    = 8'h00;
        pl_dat     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_idle", obs_vec(), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_release", obs_vec(), 32'h0);

        for (int k = 0; k < 256; k++) poke(8'(k), 8'($urandom));
        poke(8'd10, 8'd11); poke(8'd11, 8'd22); poke(8'd12, 8'd33); poke(8'd13, 8'd44);

        do_xfer("copy4", 1'b0, 10, 100, 4, 8'h00, 1'b0, 0);
        check_mem("copy4");
        check("copy4 mem[103]", {24'h0, mem[103]}, 32'd44);

        do_xfer("fillwrap", 1'b1, 0, 254, 4, 8'hA5, 1'b0, 0);
        check_mem("fillwrap");

        do_xfer("zero", 1'b0, 5, 50, 0, 8'h00, 1'b0, 0);
        do_xfer("zerofill", 1'b1, 5, 50, 0, 8'h5A, 1'b0, 0);

        do_xfer("busy_start", 1'b0, 20, 200, 3, 8'h00, 1'b1, 0);
        check_mem("busy_start");

        do_xfer("abort", 1'b1, 0, 120, 8, 8'h3C, 1'b0, 3);
        check_mem("abort");
        do_xfer("after_abort", 1'b1, 0, 130, 2, 8'h77, 1'b0, 0);
        check_mem("after_abort");

        poke(8'd0, 8'd1); poke(8'd1, 8'd2); poke(8'd2, 8'd3); poke(8'd3, 8'd4);
        do_xfer("overlap", 1'b0, 0, 1, 3, 8'h00, 1'b0, 0);
        check_mem("overlap");
        check("overlap mem[3]", {24'h0, mem[3]}, 32'd1);

        do_xfer("full", 1'b1, 0, 0, 256, 8'h00, 1'b0, 0);
        check_mem("full");

        for (int t = 0; t < 20; t++) begin
            int n;
            n = (t == 7) ? 256 : int'($urandom_range(0, 40));
            do_xfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), n, 8'($urandom), 1'($urandom_range(0, 1)) & (n >= 3), 0);
            check_mem($sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
